// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared indices, sizes and state encoding for the perf counter bank
package perf_pkg;

  localparam int NUM_CNT = 12;

  typedef enum logic [3:0] {
    IDX_CYCLES  = 4'd0,
    IDX_COMMIT  = 4'd1,
    IDX_I_REQ   = 4'd2,
    IDX_I_HIT   = 4'd3,
    IDX_D_REQ   = 4'd4,
    IDX_D_HIT   = 4'd5,
    IDX_BR      = 4'd6,
    IDX_BR_MISS = 4'd7,
    IDX_J       = 4'd8,
    IDX_J_MISS  = 4'd9,
    IDX_STALL   = 4'd10,
    IDX_BUBBLE  = 4'd11
  } perf_idx_e;

  typedef enum logic {
    COUNT  = 1'b0,
    FROZEN = 1'b1
  } perf_state_e;

endpackage

// File: rtl/perf_counter_bank_if.sv
// rtl/perf_counter_bank_if.sv - snapshot read request/acknowledge port
interface perf_counter_bank_if #(
  parameter int CNT_W = 32
);
  logic             rd_req;
  logic [3:0]       rd_sel;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;

  modport master (output rd_req, output rd_sel, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_sel, output rd_ack, output rd_data);
endinterface

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - one event counter with sticky overflow; PERF_SATURATE_EN selects saturate vs wrap
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc && !hold) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
`ifdef PERF_SATURATE_EN
        cnt_d = cnt_q;
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // The snapshot file samples the post-update value, so the next value is exported.
  assign cnt_nxt = cnt_d;
  assign ovf     = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - event counter bank with freeze, atomic snapshot and read port
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [10:0]         evt,
  input  logic                halt,
  input  logic                snap,
  input  logic                clear,
  perf_counter_bank_if.slave  rd,
  output logic                frozen,
  output logic [NUM_CNT-1:0]  ovf
);

  perf_state_e        state_q, state_d;
  logic               load;
  logic [NUM_CNT-1:0] inc_vec;
  logic [CNT_W-1:0]   cnt_nxt [NUM_CNT];
  logic [CNT_W-1:0]   snap_q  [NUM_CNT];
  logic [CNT_W-1:0]   snap_d  [NUM_CNT];
  logic               rd_ack_q, rd_ack_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic [CNT_W-1:0]   rd_val;
  logic               accept;

  always_comb begin
    state_d = state_q;
    load    = snap;
    if (clear) begin
      state_d = COUNT;
    end else if (state_q == COUNT && halt) begin
      state_d = FROZEN;
      load    = 1'b1;
    end
  end

  // Counter 0 counts cycles, so its event input is tied high.
  always_comb begin
    inc_vec = {evt, 1'b1} & {NUM_CNT{en}};
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_vec[k]),
      .clr     (clear),
      .hold    (state_q == FROZEN),
      .cnt_nxt (cnt_nxt[k]),
      .ovf     (ovf[k])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      snap_d[i] = load ? cnt_nxt[i] : snap_q[i];
    end
  end

  // Reads see the registered snapshot, so a load in the same cycle is not yet visible.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd.rd_sel == 4'(i)) begin
        rd_val = snap_q[i];
      end
    end
  end

  always_comb begin
    accept    = rd.rd_req && !rd_ack_q;
    rd_ack_d  = accept;
    rd_data_d = accept ? rd_val : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= COUNT;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < NUM_CNT; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign frozen     = (state_q == FROZEN);
  assign rd.rd_ack  = rd_ack_q;
  assign rd.rd_data = rd_data_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - scoreboard bench for perf_counter_bank (32-bit bank plus 4-bit overflow bank)
module tb_perf_counter_bank;
  import perf_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, halt, snap, clear;
  logic [10:0] evt;
  logic        frozen, frozen4;
  logic [11:0] ovf, ovf4;

  perf_counter_bank_if #(.CNT_W(32)) rd ();
  perf_counter_bank_if #(.CNT_W(4))  rd4 ();

  perf_counter_bank #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .snap(snap),
    .clear(clear), .rd(rd), .frozen(frozen), .ovf(ovf)
  );

  perf_counter_bank #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .snap(snap),
    .clear(clear), .rd(rd4), .frozen(frozen4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ack_cnt = 0;
  int          ack_base;
  logic [31:0] exp_q [$];
  logic [3:0]  exp4_q [$];
  logic        prev_ack = 1'b0;
  logic        prev_ack4 = 1'b0;
  logic [3:0]  exp_small;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd.rd_ack === 1'b1) begin
      ack_cnt++;
      check("ack_spacing", 32'(prev_ack), 32'd0);
      if (exp_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
      else check("rd_data", rd.rd_data, exp_q.pop_front());
    end
    prev_ack = (rd.rd_ack === 1'b1);
    if (rd4.rd_ack === 1'b1) begin
      if (exp4_q.size() == 0) check("unexpected_ack4", 32'd1, 32'd0);
      else check("rd_data4", 32'(rd4.rd_data), 32'(exp4_q.pop_front()));
    end
    prev_ack4 = (rd4.rd_ack === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_evt(input int b, input int n);
    repeat (n) begin
      evt = '0;
      evt[b] = 1'b1;
      @(negedge clk);
    end
    evt = '0;
  endtask

  task automatic rd_main(input logic [3:0] sel, input logic [31:0] exp);
    rd.rd_req = 1'b1;
    rd.rd_sel = sel;
    exp_q.push_back(exp);
    @(negedge clk);
    rd.rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_small(input logic [3:0] sel, input logic [3:0] exp);
    rd4.rd_req = 1'b1;
    rd4.rd_sel = sel;
    exp4_q.push_back(exp);
    @(negedge clk);
    rd4.rd_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; evt = '0; halt = 1'b0; snap = 1'b0; clear = 1'b0;
    rd.rd_req = 1'b0;  rd.rd_sel = '0;
    rd4.rd_req = 1'b0; rd4.rd_sel = '0;
    step(3);
    check("rst_frozen", 32'(frozen), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_rd_ack", 32'(rd.rd_ack), 32'd0);
    check("rst_rd_data", rd.rd_data, 32'd0);

    // 10 idle counting cycles plus the counted halt cycle
    rst = 1'b1; en = 1'b1;
    step(10);
    halt = 1'b1; step(1); halt = 1'b0;
    check("frozen_after_halt", 32'(frozen), 32'd1);
    rd_main(4'd0, 32'd11);
    rd_main(4'd1, 32'd0);

    // frozen bank ignores halt and events
    halt = 1'b1; step(1); halt = 1'b0;
    check("frozen_hold", 32'(frozen), 32'd1);
    pulse_evt(0, 3);
    snap = 1'b1; step(1); snap = 1'b0;
    rd_main(4'd1, 32'd0);
    rd_main(4'd0, 32'd11);

    clear = 1'b1; step(1); clear = 1'b0;
    check("clear_unfreezes", 32'(frozen), 32'd0);
    pulse_evt(0, 7);
    pulse_evt(3, 3);
    halt = 1'b1; step(1); halt = 1'b0;
    rd_main(4'd1, 32'd7);
    rd_main(4'd4, 32'd3);
    rd_main(4'd13, 32'd0);
    rd_main(4'd0, 32'd11);

    // clear beats halt and events
    clear = 1'b1; halt = 1'b1; step(1); clear = 1'b0; halt = 1'b0;
    check("clear_beats_halt", 32'(frozen), 32'd0);
    pulse_evt(1, 2);
    evt[1] = 1'b1; clear = 1'b1; step(1); evt = '0; clear = 1'b0;
    snap = 1'b1; step(1); snap = 1'b0;
    rd_main(4'd2, 32'd0);
    check("ovf_clear", 32'(ovf), 32'd0);

    // snapshot includes its own cycle, later events stay invisible
    pulse_evt(1, 2);
    evt[1] = 1'b1; snap = 1'b1; step(1); evt = '0; snap = 1'b0;
    pulse_evt(1, 4);
    rd_main(4'd2, 32'd3);
    snap = 1'b1; rd.rd_req = 1'b1; rd.rd_sel = 4'd2; exp_q.push_back(32'd3);
    step(1); snap = 1'b0; rd.rd_req = 1'b0;
    step(1);
    rd_main(4'd2, 32'd7);

    // held request: one accept every other cycle
    rd.rd_req = 1'b1; rd.rd_sel = 4'd2;
    repeat (3) exp_q.push_back(32'd7);
    ack_base = ack_cnt;
    step(6);
    rd.rd_req = 1'b0;
    step(2);
    check("burst_acks", 32'(ack_cnt - ack_base), 32'd3);

    // overflow on a 4-bit bank
`ifdef PERF_SATURATE_EN
    exp_small = 4'd15;
`else
    exp_small = 4'd1;
`endif
    clear = 1'b1; step(1); clear = 1'b0;
    pulse_evt(0, 17);
    snap = 1'b1; step(1); snap = 1'b0;
    rd_small(4'd1, exp_small);
    rd_main(4'd1, 32'd17);
    check("ovf4_cnt1", 32'(ovf4[1]), 32'd1);
    check("ovf4_cnt2", 32'(ovf4[2]), 32'd0);
    check("ovf_cnt1_wide", 32'(ovf[1]), 32'd0);

    // reset in the acceptance cycle cancels the ack
    halt = 1'b1; step(1); halt = 1'b0;
    check("frozen_before_rst", 32'(frozen), 32'd1);
    rd.rd_req = 1'b1; rd.rd_sel = 4'd1; rst = 1'b0;
    step(1);
    rd.rd_req = 1'b0;
    check("rst_mid_ack", 32'(rd.rd_ack), 32'd0);
    check("rst_mid_data", rd.rd_data, 32'd0);
    check("rst_mid_frozen", 32'(frozen), 32'd0);
    check("rst_mid_ovf", 32'(ovf), 32'd0);
    check("rst_mid_ovf4", 32'(ovf4), 32'd0);
    rst = 1'b1;
    step(3);
    check("scoreboard_drained", 32'(exp_q.size() + exp4_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable hardware performance-counter bank that consumes per-cycle event pulses from the CPU datapath, I-cache, D-cache and arbiter. It counts cycles, commits, cache requests/hits, branch/jump predictions/mispredictions, stalls and bubbles. On halt it freezes the counters and takes an atomic snapshot. The testbench or a debug port then reads the snapshot through a request/acknowledge interface.

## Interface
- CNT_W, 32, width of every counter and of rd_data
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- en  in  1  counting enable; 0 holds all counters
- evt  in  11  event pulses, one per cycle, bit i increments counter i+1 (index map below)
- halt  in  1  freeze request, single-cycle pulse
- snap  in  1  take a snapshot without freezing
- clear  in  1  zero all counters and overflow flags
- rd_req  in  1  read request, held until rd_ack
- rd_sel  in  4  counter index to read
- rd_ack  out  1  read data valid, one cycle
- rd_data  out  CNT_W  snapshot value of selected counter
- frozen  out  1  bank is in FROZEN state
- ovf  out  12  sticky per-counter overflow flags

## Operation
- Counter index: 0 cycles, 1 commit, 2 i_req, 3 i_hit, 4 d_req, 5 d_hit, 6 br, 7 br_miss, 8 j, 9 j_miss, 10 stall, 11 bubble. Indices 12–15 read as 0.
- States:
  - COUNT: counter 0 increments every cycle when en=1. Counter k (k≥1) increments when en=1 and evt[k-1]=1.
  - FROZEN: no counter changes.
- COUNT→FROZEN on halt. The halt cycle's own events and cycle are counted. The snapshot taken at the transition includes them.
- FROZEN→COUNT on clear, which also zeroes all counters.
- clear in COUNT zeroes all counters and stays in COUNT.
- halt while already FROZEN is ignored.
- Snapshot register file: 12×CNT_W.
  - Loaded on snap, or on entering FROZEN, with post-update counter values.
  - Unchanged by clear.
- Increment is by 1 only. Counter at all-ones plus an event follows the Configuration rule and sets ovf[k]. ovf[k] is sticky until clear or reset.
- Read handshake:
  - rd_req is accepted when rd_ack is not currently high. rd_sel is latched and the snapshot entry is captured at acceptance.
  - rd_ack pulses the following cycle with that data.
  - Throughput is one read per 2 cycles. rd_req high during the rd_ack cycle is accepted on the next cycle.
  - rd_data holds its last value when rd_ack=0.

## Timing
- Reset (rst=0 at posedge): state COUNT; all counters, snapshots, ovf = 0; rd_ack=0; rd_data=0; frozen=0.
- Reset mid-read cancels the pending ack.
- Counter updates are visible the cycle after the event. Read latency is 1 cycle from acceptance.
- frozen rises the cycle after halt.
- Simultaneous events:
  - clear + event: clear wins, counter = 0.
  - clear + halt: clear wins, state stays COUNT.
  - snap + halt: single snapshot.
  - Snapshot load + read acceptance in the same cycle: the read returns the pre-load value.

## Configuration
- PERF_SATURATE_EN defined: a counter at all-ones stays at all-ones on further events; ovf is set.
- PERF_SATURATE_EN undefined: the counter wraps to 0; ovf is set.

## Structure
- Package perf_pkg holds:
  - enum perf_idx_e (the 12 indices above)
  - localparam NUM_CNT=12
  - state enum {COUNT, FROZEN}
- Sub-module perf_counter holds one CNT_W counter with inc, clr and hold inputs, saturate/wrap logic and its ovf bit. The bank instantiates it NUM_CNT times in a generate loop.

## Test plan
- Reset, en=1, no evt for 10 cycles, halt, then read 0 → rd_data=11, frozen=1. Read 1 → 0.
- Pulse evt[0] 7× and evt[3] 3×, halt, read 1 and 4 → 7 and 3. Read 13 → 0.
- Event and clear in the same cycle on counter 2 → counter reads 0 after the next snap. ovf all 0.
- CNT_W=4: 17 events on counter 1, then snap. With PERF_SATURATE_EN → 15, ovf[1]=1. Without → 1, ovf[1]=1.
- Hold rd_req high for 6 cycles → exactly 3 rd_ack pulses, each one cycle after acceptance.
- snap, then events, then read → pre-event value. Reset asserted while a read is pending → no rd_ack, all outputs 0.
